lsu: RTL and testbench

Load/store unit that sits directly downstream of the execute-stage ALU. It takes the ALU result as the effective address and performs one RV32I load or store over a simple request/grant/response data-memory port. It handles byte-lane steering and sign/zero extension for loads. It raises precise traps for misaligned addresses and illegal access widths instead of touching memory.

---
 rtl/lsu_pkg.sv | 65 ++++++
 rtl/lsu_load_extend.sv | 27 ++
 rtl/lsu.sv | 172 +++++++++++++++++
 tb/tb_lsu.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types, opcode/cause constants and lane helpers for the load/store unit.
package lsu_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = XLEN / 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_RESP = 3'd3,
        ST_TRAP = 3'd4
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
    localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
    localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

    // Payload presented on the data-memory request port.
    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] wdata;
    } mem_cmd_t;

    function automatic logic access_illegal(input logic is_store, input logic [2:0] f3);
        if (is_store) begin
            return (f3 > F3_SW);
        end
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    function automatic logic access_misaligned(input logic [2:0] f3, input logic [1:0] off);
        return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
    endfunction

    function automatic logic [BE_W-1:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] lane_wdata(input logic [2:0] f3, input logic [XLEN-1:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Load-path lane extraction: shifts the addressed bytes down and sign/zero extends.
module load_extend
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      off_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] data_o
);

    logic [XLEN-1:0] shifted;

    assign shifted = rdata_i >> {off_i, 3'b000};

    always_comb begin
        data_o = shifted;
        case (funct3_i)
            F3_LB:   data_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   data_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_LW:   data_o = rdata_i;
            F3_LBU:  data_o = {24'd0, shifted[7:0]};
            F3_LHU:  data_o = {16'd0, shifted[15:0]};
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: one access per request over a req/gnt/rvalid data port.
// Define LSU_ACCESS_FAULT_EN to add the mem_err input and access-fault traps.
module lsu
    import lsu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [BE_W-1:0] mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
`ifdef LSU_ACCESS_FAULT_EN
    input  logic            mem_err,
`endif
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_data,
    output logic            trap,
    output logic [3:0]      trap_cause,
    output logic [XLEN-1:0] trap_tval
);

    lsu_state_e      state_q, state_d;
    logic            is_store_q, is_store_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] addr_q, addr_d;
    mem_cmd_t        cmd_q, cmd_d;
    logic            ex_ready_q, ex_ready_d;
    logic            mem_req_q, mem_req_d;
    logic            resp_valid_q, resp_valid_d;
    logic [XLEN-1:0] resp_data_q, resp_data_d;
    logic            trap_q, trap_d;
    logic [3:0]      trap_cause_q, trap_cause_d;
    logic [XLEN-1:0] trap_tval_q, trap_tval_d;
    logic [XLEN-1:0] ext_data;
    logic            fault_c;

`ifdef LSU_ACCESS_FAULT_EN
    assign fault_c = mem_err;
`else
    assign fault_c = 1'b0;
`endif

    load_extend u_load_extend (
        .rdata_i  (mem_rdata),
        .off_i    (addr_q[1:0]),
        .funct3_i (funct3_q),
        .data_o   (ext_data)
    );

    // Next-state and registered-output decode.
    always_comb begin
        state_d      = state_q;
        is_store_d   = is_store_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        cmd_d        = cmd_q;
        resp_data_d  = resp_data_q;
        trap_cause_d = trap_cause_q;
        trap_tval_d  = trap_tval_q;

        case (state_q)
            ST_IDLE: begin
                if (ex_valid) begin
                    is_store_d = is_store;
                    funct3_d   = funct3;
                    addr_d     = addr;
                    if (access_illegal(is_store, funct3)) begin
                        state_d      = ST_TRAP;
                        trap_cause_d = CAUSE_ILLEGAL;
                        trap_tval_d  = '0;
                    end else if (access_misaligned(funct3, addr[1:0])) begin
                        state_d      = ST_TRAP;
                        trap_cause_d = is_store ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
                        trap_tval_d  = addr;
                    end else begin
                        state_d     = ST_REQ;
                        cmd_d.we    = is_store;
                        cmd_d.addr  = {addr[XLEN-1:2], 2'b00};
                        cmd_d.be    = lane_be(funct3, addr[1:0]);
                        cmd_d.wdata = is_store ? lane_wdata(funct3, wdata) : '0;
                    end
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    if (!is_store_q) begin
                        state_d = ST_WAIT;
                    end else if (fault_c) begin
                        state_d      = ST_TRAP;
                        trap_cause_d = CAUSE_ST_FAULT;
                        trap_tval_d  = addr_q;
                    end else begin
                        state_d     = ST_RESP;
                        resp_data_d = '0;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    if (fault_c) begin
                        state_d      = ST_TRAP;
                        trap_cause_d = CAUSE_LD_FAULT;
                        trap_tval_d  = addr_q;
                    end else begin
                        state_d     = ST_RESP;
                        resp_data_d = ext_data;
                    end
                end
            end
            ST_RESP, ST_TRAP: state_d = ST_IDLE;
            default:          state_d = ST_IDLE;
        endcase

        ex_ready_d   = (state_d == ST_IDLE);
        mem_req_d    = (state_d == ST_REQ);
        resp_valid_d = (state_d == ST_RESP);
        trap_d       = (state_d == ST_TRAP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            is_store_q   <= 1'b0;
            funct3_q     <= '0;
            addr_q       <= '0;
            cmd_q        <= '0;
            ex_ready_q   <= 1'b1;
            mem_req_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            trap_q       <= 1'b0;
            trap_cause_q <= '0;
            trap_tval_q  <= '0;
        end else begin
            state_q      <= state_d;
            is_store_q   <= is_store_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            cmd_q        <= cmd_d;
            ex_ready_q   <= ex_ready_d;
            mem_req_q    <= mem_req_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            trap_q       <= trap_d;
            trap_cause_q <= trap_cause_d;
            trap_tval_q  <= trap_tval_d;
        end
    end

    assign ex_ready   = ex_ready_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = cmd_q.we;
    assign mem_addr   = cmd_q.addr;
    assign mem_be     = cmd_q.be;
    assign mem_wdata  = cmd_q.wdata;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign trap       = trap_q;
    assign trap_cause = trap_cause_q;
    assign trap_tval  = trap_tval_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: randomized accesses against an arithmetic reference model.
module tb_lsu;

    typedef struct packed {
        logic        is_trap;
        logic [31:0] data;
        logic [3:0]  cause;
        logic [31:0] tval;
        logic [31:0] cyc;
    } exp_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] cyc;
    } mcmd_t;

    logic        clk, rst_n, ex_valid, ex_ready, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic        resp_valid, trap;
    logic [31:0] resp_data, trap_tval;
    logic [3:0]  trap_cause;
`ifdef LSU_ACCESS_FAULT_EN
    logic        mem_err;
`endif

    int          errors = 0;
    int          checks = 0;
    logic [31:0] cyc = 0;
    exp_t        exp_q[$];
    mcmd_t       mem_q[$];

    lsu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
`ifdef LSU_ACCESS_FAULT_EN
        .mem_err    (mem_err),
`endif
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .trap       (trap),
        .trap_cause (trap_cause),
        .trap_tval  (trap_tval)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a response or a new request.
    logic        req_prev = 1'b0;
    logic        h_we;
    logic [31:0] h_addr, h_wdata;
    logic [3:0]  h_be;

    always @(negedge clk) begin : mon
        exp_t  e;
        mcmd_t m;
        if (!rst_n) begin
            req_prev <= 1'b0;
        end else begin
            if (resp_valid || trap) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got resp_valid=%0b trap=%0b, required none", resp_valid, trap);
                end else begin
                    e = exp_q.pop_front();
                    check("out_kind", {30'd0, trap, resp_valid}, e.is_trap ? 32'd2 : 32'd1);
                    check("out_cycle", cyc, e.cyc);
                    check("ex_ready_busy", {31'd0, ex_ready}, 32'd0);
                    if (e.is_trap) begin
                        check("trap_cause", {28'd0, trap_cause}, {28'd0, e.cause});
                        check("trap_tval", trap_tval, e.tval);
                    end else begin
                        check("resp_data", resp_data, e.data);
                    end
                end
            end
            if (mem_req) begin
                if (!req_prev) begin
                    if (mem_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_req: got mem_req=1 addr=0x%08h, required no request", mem_addr);
                    end else begin
                        m = mem_q.pop_front();
                        check("req_cycle", cyc, m.cyc);
                        check("mem_we", {31'd0, mem_we}, {31'd0, m.we});
                        check("mem_addr", mem_addr, m.addr);
                        if (m.we) begin
                            check("mem_be", {28'd0, mem_be}, {28'd0, m.be});
                            check("mem_wdata", mem_wdata, m.wdata);
                        end
                    end
                    h_we    <= mem_we;
                    h_addr  <= mem_addr;
                    h_be    <= mem_be;
                    h_wdata <= mem_wdata;
                end else begin
                    check("stable_we", {31'd0, mem_we}, {31'd0, h_we});
                    check("stable_addr", mem_addr, h_addr);
                    check("stable_be", {28'd0, mem_be}, {28'd0, h_be});
                    check("stable_wdata", mem_wdata, h_wdata);
                end
            end
            req_prev <= mem_req;
        end
    end

    // Issue one access in the current cycle, play the memory side, push expectations.
    task automatic run_tx(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int gd, input int rvd, input logic err);
        exp_t        e;
        mcmd_t       m;
        logic        legal;
        int          sz, off;
        logic [31:0] v;
        logic [31:0] c0;

        c0    = cyc;
        legal = st ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
        sz    = 1 << f3[1:0];
        off   = int'(a[1:0]);
        e     = '0;
        if (!legal) begin
            e.is_trap = 1'b1; e.cause = 4'd2; e.tval = 32'd0; e.cyc = c0 + 1;
        end else if ((a % sz) != 0) begin
            e.is_trap = 1'b1; e.cause = st ? 4'd6 : 4'd4; e.tval = a; e.cyc = c0 + 1;
        end else begin
            m.we   = st;
            m.addr = a & 32'hFFFF_FFFC;
            m.be   = 4'(((1 << sz) - 1) << off);
            if (sz == 1)      m.wdata = (wd & 32'hFF) * 32'h0101_0101;
            else if (sz == 2) m.wdata = (wd & 32'hFFFF) * 32'h0001_0001;
            else              m.wdata = wd;
            m.cyc = c0 + 1;
            mem_q.push_back(m);
            v = rd >> (8 * off);
            if (sz == 1) begin
                v = v & 32'hFF;
                if (!f3[2] && v >= 32'd128) v = v - 32'd256;
            end else if (sz == 2) begin
                v = v & 32'hFFFF;
                if (!f3[2] && v >= 32'd32768) v = v - 32'd65536;
            end else begin
                v = rd;
            end
            e.cyc = st ? c0 + 2 + 32'(gd) : c0 + 3 + 32'(gd) + 32'(rvd);
            if (err) begin
                e.is_trap = 1'b1; e.cause = st ? 4'd7 : 4'd5; e.tval = a;
            end else begin
                e.data = st ? 32'd0 : v;
            end
        end
        exp_q.push_back(e);

        check("ex_ready_idle", {31'd0, ex_ready}, 32'd1);
        ex_valid = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
        @(posedge clk); #1;
        ex_valid = 1'b0; is_store = 1'($urandom); funct3 = 3'($urandom);
        addr = $urandom; wdata = $urandom;
        if (e.is_trap && e.cyc == c0 + 1) begin
            @(posedge clk); #1;
            return;
        end
        repeat (gd) begin
            mem_gnt = 1'b0; mem_rvalid = 1'($urandom); mem_rdata = $urandom;
            @(posedge clk); #1;
        end
        mem_gnt = 1'b1; mem_rvalid = 1'($urandom);
`ifdef LSU_ACCESS_FAULT_EN
        mem_err = st ? err : 1'b0;
`endif
        @(posedge clk); #1;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
`ifdef LSU_ACCESS_FAULT_EN
        mem_err = 1'b0;
`endif
        if (!st) begin
            repeat (rvd) begin
                mem_gnt = 1'($urandom); mem_rdata = $urandom;
                @(posedge clk); #1;
            end
            mem_rvalid = 1'b1; mem_rdata = rd; mem_gnt = 1'($urandom);
`ifdef LSU_ACCESS_FAULT_EN
            mem_err = err;
`endif
            @(posedge clk); #1;
            mem_rvalid = 1'b0; mem_gnt = 1'b0; mem_rdata = $urandom;
`ifdef LSU_ACCESS_FAULT_EN
            mem_err = 1'b0;
`endif
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ex_ready"}, {31'd0, ex_ready}, 32'd1);
        check({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
        check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        check({tag, "_mem_be"}, {28'd0, mem_be}, 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        check({tag, "_resp_data"}, resp_data, 32'd0);
        check({tag, "_trap"}, {31'd0, trap}, 32'd0);
        check({tag, "_trap_cause"}, {28'd0, trap_cause}, 32'd0);
        check({tag, "_trap_tval"}, trap_tval, 32'd0);
    endtask

    initial begin
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;

        rst_n = 1'b0; ex_valid = 1'b0; is_store = 1'b0; funct3 = '0; addr = '0; wdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
`ifdef LSU_ACCESS_FAULT_EN
        mem_err = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_tx(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0, 0, 1'b0);
        run_tx(1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0, 0, 1'b0);
        run_tx(1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 0, 0, 1'b0);
        run_tx(1'b0, 3'b010, 32'h0000_0105, 32'h0, 32'h0, 0, 0, 1'b0);
        run_tx(1'b1, 3'b010, 32'h0000_0400, 32'hDEAD_BEEF, 32'h0, 3, 0, 1'b0);
        run_tx(1'b0, 3'b011, 32'h0000_0044, 32'h0, 32'h0, 0, 0, 1'b0);
        run_tx(1'b0, 3'b001, 32'h0000_0042, 32'h0, 32'h1234_8001, 1, 2, 1'b0);
        run_tx(1'b0, 3'b101, 32'h0000_0042, 32'h0, 32'h8765_4321, 0, 1, 1'b0);
        run_tx(1'b1, 3'b000, 32'h0000_0011, 32'h1234_56A5, 32'h0, 2, 0, 1'b0);
        run_tx(1'b1, 3'b001, 32'h0000_0013, 32'h1234_56A5, 32'h0, 0, 0, 1'b0);
        run_tx(1'b1, 3'b100, 32'h0000_0010, 32'h1234_56A5, 32'h0, 0, 0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            st = 1'($urandom);
            f3 = 3'($urandom);
            if ($urandom_range(7, 0) != 0) begin
                if (st) f3 = 3'($urandom_range(2, 0));
                else    f3 = ($urandom_range(1, 0) == 1) ? 3'($urandom_range(5, 4)) : 3'($urandom_range(2, 0));
            end
            a = $urandom;
            if ($urandom_range(3, 0) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
            run_tx(st, f3, a, $urandom, $urandom, int'($urandom_range(3, 0)),
                   int'($urandom_range(3, 0)), 1'b0);
        end

`ifdef LSU_ACCESS_FAULT_EN
        run_tx(1'b1, 3'b010, 32'h0000_0800, 32'h5555_AAAA, 32'h0, 0, 0, 1'b1);
        run_tx(1'b0, 3'b010, 32'h0000_0804, 32'h0, 32'h1111_2222, 1, 1, 1'b1);
        run_tx(1'b0, 3'b010, 32'h0000_0808, 32'h0, 32'h3333_4444, 0, 0, 1'b0);
`endif

        // Reset while a load waits for data; a late rvalid must produce nothing.
        begin
            mcmd_t m;
            m = '{we: 1'b0, addr: 32'h0000_0040, be: 4'hF, wdata: 32'h0, cyc: cyc + 1};
            mem_q.push_back(m);
            ex_valid = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0040;
            @(posedge clk); #1;
            ex_valid = 1'b0;
            mem_gnt = 1'b1;
            @(posedge clk); #1;
            mem_gnt = 1'b0;
            rst_n = 1'b0;
            #2;
            check_reset_outputs("midrst");
            @(posedge clk); #1;
            rst_n = 1'b1;
            mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            check_reset_outputs("postrst");
        end

        run_tx(1'b0, 3'b000, 32'h0000_0021, 32'h0, 32'h0000_7F00, 0, 0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("resp_queue_empty", 32'(exp_q.size()), 32'd0);
        check("req_queue_empty", 32'(mem_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
